// File: rtl/wall_collision_detector_pkg.sv
// Shared table constants, wall codes and local FSM/debug types for the
// wall/bevel contact detector.
package wall_collision_detector_pkg;

  // Table extents and ball/corner geometry defaults, unsigned pixel coords
  localparam int X_MIN_DEF           = 0;
  localparam int X_MAX_DEF           = 1279;
  localparam int Y_MIN_DEF           = 0;
  localparam int Y_MAX_DEF           = 719;
  localparam int BALL_R_DEF          = 8;
  localparam int BEVEL_DEF           = 32;
  localparam int COOLDOWN_FRAMES_DEF = 4;

  // Heading constants, degrees; 0 = +x, 90 = +y
  localparam logic [15:0] DEG_90  = 16'd90;
  localparam logic [15:0] DEG_180 = 16'd180;
  localparam logic [15:0] DEG_270 = 16'd270;
  localparam logic [15:0] DEG_360 = 16'd360;

  // Width of the geometry intermediates
  localparam int COORD_W = 12;

  // Candidate vector: one bit per wall code
  localparam int CAND_W = 8;
  localparam int CB_PX  = 0;  // code 0
  localparam int CB_PY  = 1;  // code 1
  localparam int CB_NX  = 2;  // code 2
  localparam int CB_NY  = 3;  // code 3
  localparam int CB_B4  = 4;  // code 4  (+x,-y) corner
  localparam int CB_B6  = 5;  // code 6  (+x,+y) corner
  localparam int CB_B8  = 6;  // code 8  (-x,+y) corner
  localparam int CB_B10 = 7;  // code 10 (-x,-y) corner

  // Cooldown counter width (must hold COOLDOWN_FRAMES)
  localparam int CD_W = 3;

  // Wall codes as consumed by reflection_helper
  typedef enum logic [3:0] {
    WALL_PX      = 4'd0,
    WALL_PY      = 4'd1,
    WALL_NX      = 4'd2,
    WALL_NY      = 4'd3,
    WALL_B_PX_NY = 4'd4,
    WALL_B_PX_PY = 4'd6,
    WALL_B_NX_PY = 4'd8,
    WALL_B_NX_NY = 4'd10
  } wall_code_e;

  // "No code accepted yet" marker for the cooldown history
  localparam logic [3:0] CODE_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2
  } state_e;

  // Internal state exposed for observation
  typedef struct packed {
    state_e            state;
    logic [CD_W-1:0]   cooldown;
    logic [3:0]        last_code;
  } dbg_t;

  // Map a wall code to its candidate-vector bit; unknown codes map to nothing
  function automatic logic [CAND_W-1:0] code_to_cand(input logic [3:0] code);
    logic [CAND_W-1:0] v;
    v = '0;
    case (code)
      4'd0:    v[CB_PX]  = 1'b1;
      4'd1:    v[CB_PY]  = 1'b1;
      4'd2:    v[CB_NX]  = 1'b1;
      4'd3:    v[CB_NY]  = 1'b1;
      4'd4:    v[CB_B4]  = 1'b1;
      4'd6:    v[CB_B6]  = 1'b1;
      4'd8:    v[CB_B8]  = 1'b1;
      4'd10:   v[CB_B10] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wall_collision_detector_if.sv
// Wall-code hand-off from the detector (master) to ball physics (slave).
//
// Handshake: hit_valid_out is raised by the master with wall_direction_out;
// both are held stable until hit_ready_in is seen high. A transfer happens on
// the rising clock edge where hit_valid_out && hit_ready_in; valid drops on
// the following cycle. The slave may hold ready high or low at any time.
interface wall_collision_detector_if;
  import wall_collision_detector_pkg::*;

  logic       hit_valid_out;
  logic       hit_ready_in;
  wall_code_e wall_direction_out;

  modport master (
    output hit_valid_out,
    output wall_direction_out,
    input  hit_ready_in
  );

  modport slave (
    input  hit_valid_out,
    input  wall_direction_out,
    output hit_ready_in
  );

endinterface

// File: rtl/wall_collision_detector_geometry.sv
// Purely combinational contact test: compares ball centre and heading
// against the four walls and the four bevelled corners and returns one
// candidate bit per wall code. No masking or priority is applied here.
module wall_collision_detector_geometry
  import wall_collision_detector_pkg::*;
#(
  parameter int X_MIN  = X_MIN_DEF,
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MIN  = Y_MIN_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int BALL_R = BALL_R_DEF,
  parameter int BEVEL  = BEVEL_DEF
) (
  input  logic [10:0]       i_x,
  input  logic [9:0]        i_y,
  input  logic [15:0]       i_dir,
  output logic [CAND_W-1:0] o_cand
);

  localparam logic [COORD_W-1:0] LP_X_MIN = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] LP_X_MAX = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] LP_Y_MIN = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] LP_Y_MAX = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] LP_R     = COORD_W'(BALL_R);
  localparam logic [COORD_W-1:0] LP_NEAR  = COORD_W'(BEVEL + BALL_R);

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  assign w_x = {1'b0, i_x};
  assign w_y = {2'b00, i_y};

  // Heading tests use strict bounds; a heading of 360 or more matches nothing
  logic w_dir_ok, w_to_px, w_to_nx, w_to_py, w_to_ny;
  assign w_dir_ok = (i_dir < DEG_360);
  assign w_to_px  = w_dir_ok & ((i_dir < DEG_90) | (i_dir > DEG_270));
  assign w_to_nx  = (i_dir > DEG_90) & (i_dir < DEG_270);
  assign w_to_py  = (i_dir != 16'd0) & (i_dir < DEG_180);
  assign w_to_ny  = w_dir_ok & (i_dir > DEG_180);

  // Flat-wall proximity: ball edge touching or past the wall line
  logic w_near_px, w_near_nx, w_near_py, w_near_ny;
  assign w_near_px = ((w_x + LP_R) >= LP_X_MAX);
  assign w_near_nx = (w_x <= (LP_X_MIN + LP_R));
  assign w_near_py = ((w_y + LP_R) >= LP_Y_MAX);
  assign w_near_ny = (w_y <= (LP_Y_MIN + LP_R));

  // Distances to each corner axis, one bit wider so the top bit flags a
  // borrow; a borrow means the ball is outside that extent and never "near"
  logic [COORD_W:0] w_sub_xhi, w_sub_xlo, w_sub_yhi, w_sub_ylo;
  assign w_sub_xhi = {1'b0, LP_X_MAX} - {1'b0, w_x};
  assign w_sub_xlo = {1'b0, w_x} - {1'b0, LP_X_MIN};
  assign w_sub_yhi = {1'b0, LP_Y_MAX} - {1'b0, w_y};
  assign w_sub_ylo = {1'b0, w_y} - {1'b0, LP_Y_MIN};

  logic w_xhi_ok, w_xlo_ok, w_yhi_ok, w_ylo_ok;
  assign w_xhi_ok = ~w_sub_xhi[COORD_W];
  assign w_xlo_ok = ~w_sub_xlo[COORD_W];
  assign w_yhi_ok = ~w_sub_yhi[COORD_W];
  assign w_ylo_ok = ~w_sub_ylo[COORD_W];

  logic [COORD_W-1:0] w_dx_hi, w_dx_lo, w_dy_hi, w_dy_lo;
  assign w_dx_hi = w_sub_xhi[COORD_W-1:0];
  assign w_dx_lo = w_sub_xlo[COORD_W-1:0];
  assign w_dy_hi = w_sub_yhi[COORD_W-1:0];
  assign w_dy_lo = w_sub_ylo[COORD_W-1:0];

  // L1 distance to each corner, widened so the sum cannot wrap
  logic [COORD_W:0] w_l1_b4, w_l1_b6, w_l1_b8, w_l1_b10;
  assign w_l1_b4  = {1'b0, w_dx_hi} + {1'b0, w_dy_lo};
  assign w_l1_b6  = {1'b0, w_dx_hi} + {1'b0, w_dy_hi};
  assign w_l1_b8  = {1'b0, w_dx_lo} + {1'b0, w_dy_hi};
  assign w_l1_b10 = {1'b0, w_dx_lo} + {1'b0, w_dy_lo};

  logic w_near_b4, w_near_b6, w_near_b8, w_near_b10;
  assign w_near_b4  = w_xhi_ok & w_ylo_ok & (w_l1_b4  <= {1'b0, LP_NEAR});
  assign w_near_b6  = w_xhi_ok & w_yhi_ok & (w_l1_b6  <= {1'b0, LP_NEAR});
  assign w_near_b8  = w_xlo_ok & w_yhi_ok & (w_l1_b8  <= {1'b0, LP_NEAR});
  assign w_near_b10 = w_xlo_ok & w_ylo_ok & (w_l1_b10 <= {1'b0, LP_NEAR});

  // Combine proximity and heading into one candidate bit per code
  always_comb begin
    o_cand         = '0;
    o_cand[CB_PX]  = w_near_px & w_to_px;
    o_cand[CB_NX]  = w_near_nx & w_to_nx;
    o_cand[CB_PY]  = w_near_py & w_to_py;
    o_cand[CB_NY]  = w_near_ny & w_to_ny;
    o_cand[CB_B4]  = w_near_b4  & w_to_px & w_to_ny;
    o_cand[CB_B6]  = w_near_b6  & w_to_px & w_to_py;
    o_cand[CB_B8]  = w_near_b8  & w_to_nx & w_to_py;
    o_cand[CB_B10] = w_near_b10 & w_to_nx & w_to_ny;
  end

endmodule

// File: rtl/wall_collision_detector.sv
// Per-frame wall/bevel contact detector. On each accepted frame tick it
// evaluates the geometry, masks the most recently accepted code while its
// cooldown runs, picks one code by priority and offers it downstream.
module wall_collision_detector
  import wall_collision_detector_pkg::*;
#(
  parameter int X_MIN           = X_MIN_DEF,
  parameter int X_MAX           = X_MAX_DEF,
  parameter int Y_MIN           = Y_MIN_DEF,
  parameter int Y_MAX           = Y_MAX_DEF,
  parameter int BALL_R          = BALL_R_DEF,
  parameter int BEVEL           = BEVEL_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        frame_in,
  input  logic [10:0]                 ball_x_in,
  input  logic [9:0]                  ball_y_in,
  input  logic [15:0]                 ball_direction_in,
  wall_collision_detector_if.master   hit_if,
  output dbg_t                        dbg_out
);

  localparam logic [CD_W-1:0] LP_COOLDOWN = CD_W'(COOLDOWN_FRAMES);

  state_e             r_state;
  state_e             w_next_state;
  logic               r_valid;
  wall_code_e         r_code;
  logic [3:0]         r_last_code;
  logic [CD_W-1:0]    r_cooldown;
  logic               r_mask_en;
  logic [3:0]         r_mask_code;

  logic [CAND_W-1:0]  w_cand;
  logic [CAND_W-1:0]  w_cand_masked;
  logic               w_hit;
  wall_code_e         w_pick;
  logic               w_xfer;

  wall_collision_detector_geometry #(
    .X_MIN  (X_MIN),
    .X_MAX  (X_MAX),
    .Y_MIN  (Y_MIN),
    .Y_MAX  (Y_MAX),
    .BALL_R (BALL_R),
    .BEVEL  (BEVEL)
  ) u_geometry (
    .i_x    (ball_x_in),
    .i_y    (ball_y_in),
    .i_dir  (ball_direction_in),
    .o_cand (w_cand)
  );

  assign w_xfer = (r_state == EMIT) & r_valid & hit_if.hit_ready_in;

  // The mask snapshot is taken when the frame is accepted, so the frame that
  // runs the cooldown down to zero is itself still masked
  assign w_cand_masked = w_cand & ~(r_mask_en ? code_to_cand(r_mask_code) : '0);
  assign w_hit         = |w_cand_masked;

  // Priority: bevels first, then x walls, then y walls
  always_comb begin
    w_pick = WALL_PX;
    if      (w_cand_masked[CB_B4])  w_pick = WALL_B_PX_NY;
    else if (w_cand_masked[CB_B6])  w_pick = WALL_B_PX_PY;
    else if (w_cand_masked[CB_B8])  w_pick = WALL_B_NX_PY;
    else if (w_cand_masked[CB_B10]) w_pick = WALL_B_NX_NY;
    else if (w_cand_masked[CB_PX])  w_pick = WALL_PX;
    else if (w_cand_masked[CB_NX])  w_pick = WALL_NX;
    else if (w_cand_masked[CB_PY])  w_pick = WALL_PY;
    else if (w_cand_masked[CB_NY])  w_pick = WALL_NY;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; frames arriving outside IDLE are dropped
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (frame_in) w_next_state = CHECK;
      CHECK:   w_next_state = w_hit ? EMIT : IDLE;
      EMIT:    if (hit_if.hit_ready_in) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output registers: load in CHECK on a hit, hold through EMIT, drop on transfer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= 1'b0;
      r_code  <= WALL_PX;
    end else if ((r_state == CHECK) && w_hit) begin
      r_valid <= 1'b1;
      r_code  <= w_pick;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  // Cooldown history: arm on transfer, count down and snapshot on accepted frames
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last_code <= CODE_NONE;
      r_cooldown  <= '0;
      r_mask_en   <= 1'b0;
      r_mask_code <= CODE_NONE;
    end else if (w_xfer) begin
      r_last_code <= r_code;
      r_cooldown  <= LP_COOLDOWN;
    end else if ((r_state == IDLE) && frame_in) begin
      r_mask_en   <= (r_cooldown != '0);
      r_mask_code <= r_last_code;
      if (r_cooldown != '0) r_cooldown <= r_cooldown - 1'b1;
    end
  end

  assign hit_if.hit_valid_out      = r_valid;
  assign hit_if.wall_direction_out = r_code;

  assign dbg_out.state     = r_state;
  assign dbg_out.cooldown  = r_cooldown;
  assign dbg_out.last_code = r_last_code;

endmodule

// File: tb/tb_wall_collision_detector.sv
// Directed bench for the wall/bevel contact detector.
module tb_wall_collision_detector;
  import wall_collision_detector_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic [10:0] bx = '0;
  logic [9:0]  by = '0;
  logic [15:0] bd = '0;
  dbg_t        dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int xfer_cnt = 0;
  logic [3:0] exp_q[$];

  wall_collision_detector_if u_if ();

  wall_collision_detector dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .frame_in          (frame),
    .ball_x_in         (bx),
    .ball_y_in         (by),
    .ball_direction_in (bd),
    .hit_if            (u_if),
    .dbg_out           (dbg)
  );

  // Clock and transfer counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && u_if.hit_valid_out && u_if.hit_ready_in) xfer_cnt <= xfer_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame = 1'b0;
    u_if.hit_ready_in = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pulse frame at cycle N; returns sampling cycle N+2
  task automatic send_frame(input int x, input int y, input int d);
    bx = 11'(x);
    by = 10'(y);
    bd = 16'(d);
    frame = 1'b1;
    step();
    frame = 1'b0;
    step();
  endtask

  task automatic test_reset();
    u_if.hit_ready_in = 1'b0;
    rst = 1'b1;
    step();
    step();
    n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", u_if.hit_valid_out); end
    n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", u_if.wall_direction_out); end
    n_tests++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg.state); end
    n_tests++; if (dbg.cooldown !== 3'd0) begin n_fail++; $display("FAIL reset_cooldown: got %0d expected 0", dbg.cooldown); end
    n_tests++; if (dbg.last_code !== 4'hF) begin n_fail++; $display("FAIL reset_last_code: got %0h expected f", dbg.last_code); end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    u_if.hit_ready_in = 1'b1;
    bx = 11'd1271; by = 10'd360; bd = 16'd30;
    frame = 1'b1;
    step();
    frame = 1'b0;
    n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL lat_n1_valid: got %0b expected 0", u_if.hit_valid_out); end
    n_tests++; if (dbg.state !== CHECK) begin n_fail++; $display("FAIL lat_n1_state: got %0d expected 1", dbg.state); end
    step();
    n_tests++; if (u_if.hit_valid_out !== 1'b1) begin n_fail++; $display("FAIL lat_n2_valid: got %0b expected 1", u_if.hit_valid_out); end
    n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL lat_n2_code: got %0d expected 0", u_if.wall_direction_out); end
    step();
    n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL lat_n3_valid: got %0b expected 0", u_if.hit_valid_out); end
    n_tests++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL lat_n3_state: got %0d expected 0", dbg.state); end
  endtask

  // Geometry table: x, y, heading, hit expected, code expected
  task automatic test_geometry();
    int vx [16] = '{1271, 1271, 1260, 1270, 1271, 1271,    8,  640,
                      10,   20, 1259, 1259,  640,    8, 1271, 1271};
    int vy [16] = '{ 360,  360,  700,  360,  360,  360,  360,    8,
                      10,  699,   20,   21,  711,  360,  360,  360};
    int vd [16] = '{  30,  150,   45,   30,   90,    0,  180,  270,
                     225,  135,  315,  315,   90,  270,  271,  359};
    bit vh [16] = '{1, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 1};
    int vc [16] = '{0, 0, 6, 0, 0, 0, 2, 3, 10, 8, 4, 0, 1, 0, 0, 0};
    logic [3:0] exp_code;
    for (int i = 0; i < 16; i++) begin
      do_reset();
      u_if.hit_ready_in = 1'b1;
      if (vh[i]) exp_q.push_back(4'(vc[i]));
      send_frame(vx[i], vy[i], vd[i]);
      n_tests++; if (u_if.hit_valid_out !== vh[i]) begin n_fail++; $display("FAIL geom_valid[%0d]: got %0b expected %0b", i, u_if.hit_valid_out, vh[i]); end
      if (vh[i]) begin
        exp_code = exp_q.pop_front();
        n_tests++; if (u_if.wall_direction_out !== exp_code) begin n_fail++; $display("FAIL geom_code[%0d]: got %0d expected %0d", i, u_if.wall_direction_out, exp_code); end
      end else begin
        n_tests++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL geom_idle[%0d]: got %0d expected 0", i, dbg.state); end
      end
      step();
      n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL geom_drop[%0d]: got %0b expected 0", i, u_if.hit_valid_out); end
    end
  endtask

  task automatic test_back_pressure();
    int x0;
    do_reset();
    u_if.hit_ready_in = 1'b0;
    x0 = xfer_cnt;
    send_frame(1271, 360, 30);
    for (int i = 0; i < 6; i++) begin
      frame = (i == 1 || i == 3);
      bx = 11'd640; by = 10'd713;
      n_tests++; if (u_if.hit_valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %0b expected 1", i, u_if.hit_valid_out); end
      n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL stall_code[%0d]: got %0d expected 0", i, u_if.wall_direction_out); end
      step();
    end
    frame = 1'b0;
    n_tests++; if (dbg.state !== EMIT) begin n_fail++; $display("FAIL stall_state: got %0d expected 2", dbg.state); end
    u_if.hit_ready_in = 1'b1;
    n_tests++; if (u_if.hit_valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %0b expected 1", u_if.hit_valid_out); end
    step();
    n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_after_valid: got %0b expected 0", u_if.hit_valid_out); end
    step(); step(); step();
    n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_no_requeue: got %0b expected 0", u_if.hit_valid_out); end
    n_tests++; if ((xfer_cnt - x0) !== 1) begin n_fail++; $display("FAIL stall_xfer_count: got %0d expected 1", xfer_cnt - x0); end
  endtask

  task automatic test_cooldown();
    do_reset();
    u_if.hit_ready_in = 1'b1;
    send_frame(1271, 360, 30);
    n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL cd_first_code: got %0d expected 0", u_if.wall_direction_out); end
    step();
    n_tests++; if (dbg.cooldown !== 3'd4) begin n_fail++; $display("FAIL cd_armed: got %0d expected 4", dbg.cooldown); end
    n_tests++; if (dbg.last_code !== 4'd0) begin n_fail++; $display("FAIL cd_last_code: got %0d expected 0", dbg.last_code); end
    for (int f = 1; f <= 4; f++) begin
      send_frame(1271, 360, 30);
      n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL cd_masked[%0d]: got %0b expected 0", f, u_if.hit_valid_out); end
    end
    n_tests++; if (dbg.cooldown !== 3'd0) begin n_fail++; $display("FAIL cd_expired: got %0d expected 0", dbg.cooldown); end
    send_frame(1271, 360, 30);
    n_tests++; if (u_if.hit_valid_out !== 1'b1) begin n_fail++; $display("FAIL cd_fifth_valid: got %0b expected 1", u_if.hit_valid_out); end
    n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL cd_fifth_code: got %0d expected 0", u_if.wall_direction_out); end
    step();
    // A different code is not held back by the cooldown
    do_reset();
    u_if.hit_ready_in = 1'b1;
    send_frame(1271, 360, 30);
    step();
    send_frame(640, 713, 30);
    n_tests++; if (u_if.hit_valid_out !== 1'b1) begin n_fail++; $display("FAIL cd_other_valid: got %0b expected 1", u_if.hit_valid_out); end
    n_tests++; if (u_if.wall_direction_out !== 4'd1) begin n_fail++; $display("FAIL cd_other_code: got %0d expected 1", u_if.wall_direction_out); end
    step();
    // Masked bevel lets the next-priority flat code win
    do_reset();
    u_if.hit_ready_in = 1'b1;
    send_frame(1271, 713, 45);
    n_tests++; if (u_if.wall_direction_out !== 4'd6) begin n_fail++; $display("FAIL cd_bevel_code: got %0d expected 6", u_if.wall_direction_out); end
    step();
    send_frame(1271, 713, 45);
    n_tests++; if (u_if.hit_valid_out !== 1'b1) begin n_fail++; $display("FAIL cd_fallback_valid: got %0b expected 1", u_if.hit_valid_out); end
    n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL cd_fallback_code: got %0d expected 0", u_if.wall_direction_out); end
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    u_if.hit_ready_in = 1'b1;
    send_frame(1271, 360, 30);
    step();
    u_if.hit_ready_in = 1'b0;
    send_frame(640, 713, 30);
    n_tests++; if (u_if.wall_direction_out !== 4'd1) begin n_fail++; $display("FAIL mr_pending_code: got %0d expected 1", u_if.wall_direction_out); end
    n_tests++; if (dbg.cooldown !== 3'd3) begin n_fail++; $display("FAIL mr_pending_cd: got %0d expected 3", dbg.cooldown); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %0b expected 0", u_if.hit_valid_out); end
    n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL mr_code: got %0d expected 0", u_if.wall_direction_out); end
    n_tests++; if (dbg.cooldown !== 3'd0) begin n_fail++; $display("FAIL mr_cooldown: got %0d expected 0", dbg.cooldown); end
    n_tests++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL mr_state: got %0d expected 0", dbg.state); end
    u_if.hit_ready_in = 1'b1;
    send_frame(1271, 360, 30);
    n_tests++; if (u_if.hit_valid_out !== 1'b1) begin n_fail++; $display("FAIL mr_reemit_valid: got %0b expected 1", u_if.hit_valid_out); end
    n_tests++; if (u_if.wall_direction_out !== 4'd0) begin n_fail++; $display("FAIL mr_reemit_code: got %0d expected 0", u_if.wall_direction_out); end
    step();
  endtask

  task automatic test_bad_direction();
    int dirs [2] = '{400, 360};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      u_if.hit_ready_in = 1'b1;
      send_frame(1271, 360, dirs[i]);
      n_tests++; if (u_if.hit_valid_out !== 1'b0) begin n_fail++; $display("FAIL baddir_valid[%0d]: got %0b expected 0", dirs[i], u_if.hit_valid_out); end
      n_tests++; if (dbg.state !== IDLE) begin n_fail++; $display("FAIL baddir_state[%0d]: got %0d expected 0", dirs[i], dbg.state); end
    end
  endtask

  initial begin
    u_if.hit_ready_in = 1'b0;
    test_reset();
    test_latency();
    test_geometry();
    test_back_pressure();
    test_cooldown();
    test_mid_reset();
    test_bad_direction();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
